// File: rtl/pwm_peripheral_if.sv
// Register-side bundle between the SPI register block and the PWM output stage.
// The master drives the enable/duty registers; the slave returns the output bus.
interface pwm_peripheral_if;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;

  modport master (
    output en_reg_out_7_0,
    output en_reg_out_15_8,
    output en_reg_pwm_7_0,
    output en_reg_pwm_15_8,
    output pwm_duty_cycle,
    input  out,
    input  period_start
  );

  modport slave (
    input  en_reg_out_7_0,
    input  en_reg_out_15_8,
    input  en_reg_pwm_7_0,
    input  en_reg_pwm_15_8,
    input  pwm_duty_cycle,
    output out,
    output period_start
  );
endinterface

// File: rtl/pwm_peripheral.sv
// Drives 16 outputs as off, static on, or PWM from one shared 8-bit generator.
// Duty is double-buffered and only taken at the period wrap, so waveforms never glitch.
module pwm_peripheral #(
  parameter int unsigned CLK_DIV = 3000  // system clocks per PWM tick, 1..65535
) (
  input logic             clk,
  input logic             rst,
  pwm_peripheral_if.slave bus
);

  localparam logic [15:0] PrescMax = 16'(CLK_DIV - 1);

  logic [15:0] presc_q, presc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  duty_q, duty_d;
  logic [15:0] out_q, out_d;
  logic        period_start_q, period_start_d;

  logic        tick;
  logic        pwm_level;
  logic [15:0] en_out;
  logic [15:0] en_pwm;

  assign en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
  assign en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
  assign tick   = (presc_q == PrescMax);

  // 0xFF is full-on with no dropout at the wrap; otherwise compare against the period count.
  assign pwm_level = (duty_q == 8'hFF) || (cnt_q < duty_q);

  // Next-state for counters, duty shadow and the registered output bus.
  always_comb begin
    presc_d        = tick ? 16'd0 : presc_q + 16'd1;
    cnt_d          = tick ? cnt_q + 8'd1 : cnt_q;
    // Shadow loads only on the edge where the period counter wraps to 0.
    duty_d         = (tick && (cnt_q == 8'hFF)) ? bus.pwm_duty_cycle : duty_q;
    // en_pwm is a don't-care for disabled bits.
    out_d          = en_out & (~en_pwm | {16{pwm_level}});
    period_start_d = (cnt_q == 8'd0) && (presc_q == 16'd0);
  end

  // State update with synchronous reset; a reset mid-period aborts that period.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q        <= 16'd0;
      cnt_q          <= 8'd0;
      duty_q         <= 8'h00;
      out_q          <= 16'h0000;
      period_start_q <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      cnt_q          <= cnt_d;
      duty_q         <= duty_d;
      out_q          <= out_d;
      period_start_q <= period_start_d;
    end
  end

  assign bus.out          = out_q;
  assign bus.period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Scoreboard bench for pwm_peripheral with CLK_DIV=4 (1024-clock period).
// The reference model tracks only the cycle index since reset release and the duty of
// the current period; counter values are derived from it arithmetically.
module tb_pwm_peripheral;

  localparam int unsigned Div    = 4;
  localparam int unsigned Period = 256 * Div;

  typedef struct {
    int unsigned cyc;
    logic [15:0] out;
    logic        ps;
  } exp_t;

  logic clk;
  logic rst;

  pwm_peripheral_if bus ();

  pwm_peripheral #(
    .CLK_DIV(Div)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int unsigned cyc;       // posedge count
  int unsigned n;         // model: cycles since reset release for the cycle being driven
  logic [7:0]  duty_cur;  // model: duty in force for the current period
  exp_t        sb[$];
  int unsigned total;
  int unsigned bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Drive one cycle of inputs and push the output expected on the following cycle.
  task automatic step(input logic r, input logic [15:0] eo, input logic [15:0] ep,
                      input logic [7:0] dc);
    exp_t        e;
    int unsigned cnt;
    logic        lvl;
    @(posedge clk);
    #1;
    rst                 = r;
    bus.en_reg_out_7_0  = eo[7:0];
    bus.en_reg_out_15_8 = eo[15:8];
    bus.en_reg_pwm_7_0  = ep[7:0];
    bus.en_reg_pwm_15_8 = ep[15:8];
    bus.pwm_duty_cycle  = dc;
    e.cyc = cyc + 1;
    if (r) begin
      e.out    = 16'h0000;
      e.ps     = 1'b0;
      n        = 0;
      duty_cur = 8'h00;
    end else begin
      cnt = (n / Div) % 256;
      lvl = (duty_cur == 8'hFF) || (cnt < duty_cur);
      for (int i = 0; i < 16; i++) begin
        e.out[i] = eo[i] ? (ep[i] ? lvl : 1'b1) : 1'b0;
      end
      e.ps = ((n % Period) == 0);
      if ((n % Period) == Period - 1) duty_cur = dc;
      n = n + 1;
    end
    sb.push_back(e);
  endtask

  // Hold inputs until the next cycle to be driven sits at the given period phase.
  task automatic hold_until(input int unsigned phase, input logic [15:0] eo,
                            input logic [15:0] ep, input logic [7:0] dc);
    while ((n % Period) != phase) step(1'b0, eo, ep, dc);
  endtask

  task automatic hold(input int unsigned cycles, input logic [15:0] eo,
                      input logic [15:0] ep, input logic [7:0] dc);
    for (int i = 0; i < cycles; i++) step(1'b0, eo, ep, dc);
  endtask

  // Monitor: the DUT presents out/period_start every cycle; compare against queued entries.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      while (sb.size() != 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        total = total + 1;
        bad   = bad + 1;
        $display("FAIL stale_entry cyc=%0d: expected entry never compared (want out=%h ps=%b)",
                 e.cyc, e.out, e.ps);
      end
      if (sb.size() != 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        total = total + 1;
        if (bus.out !== e.out || bus.period_start !== e.ps) begin
          bad = bad + 1;
          $display("FAIL out_check cyc=%0d: got out=%h ps=%b, want out=%h ps=%b",
                   cyc, bus.out, bus.period_start, e.out, e.ps);
        end
      end
    end
  end

  initial begin
    total    = 0;
    bad      = 0;
    n        = 0;
    duty_cur = 8'h00;
    rst      = 1'b1;
    bus.en_reg_out_7_0  = 8'hFF;
    bus.en_reg_out_15_8 = 8'hFF;
    bus.en_reg_pwm_7_0  = 8'hFF;
    bus.en_reg_pwm_15_8 = 8'hFF;
    bus.pwm_duty_cycle  = 8'hFF;

    // Reset with everything high; first period must stay dark since the shadow is 0.
    for (int i = 0; i < 3; i++) step(1'b1, 16'hFFFF, 16'hFFFF, 8'hFF);
    hold(Period + 50, 16'hFFFF, 16'hFFFF, 8'hFF);

    // Static modes: high byte off, bits 7:4 on, bits 3:0 at half duty.
    hold(2 * Period, 16'h00FF, 16'h000F, 8'h80);

    // Duty extremes with all bits in PWM mode.
    hold_until(0, 16'hFFFF, 16'hFFFF, 8'h00);
    hold(Period, 16'hFFFF, 16'hFFFF, 8'h00);
    hold(2 * Period, 16'hFFFF, 16'hFFFF, 8'hFF);

    // Double buffer: mid-period write, then a write on exactly the wrap cycle.
    hold(Period, 16'hFFFF, 16'hFFFF, 8'h40);
    hold_until(512, 16'hFFFF, 16'hFFFF, 8'h40);
    hold(Period, 16'hFFFF, 16'hFFFF, 8'hC0);
    hold_until(0, 16'hFFFF, 16'hFFFF, 8'h40);
    hold_until(Period - 1, 16'hFFFF, 16'hFFFF, 8'h40);
    step(1'b0, 16'hFFFF, 16'hFFFF, 8'hC0);
    hold(Period, 16'hFFFF, 16'hFFFF, 8'h40);

    // Enable toggle while out[0] is high in PWM mode.
    hold_until(0, 16'hFFFF, 16'hFFFF, 8'h80);
    hold_until(100, 16'hFFFF, 16'hFFFF, 8'h80);
    hold(10, 16'hFFFE, 16'hFFFF, 8'h80);
    hold(Period, 16'hFFFF, 16'hFFFF, 8'h80);

    // Reset mid-operation with duty 0xC0 latched.
    hold_until(0, 16'hFFFF, 16'hFFFF, 8'hC0);
    hold(Period + 400, 16'hFFFF, 16'hFFFF, 8'hC0);
    step(1'b1, 16'hFFFF, 16'hFFFF, 8'hC0);
    hold(2 * Period + 20, 16'hFFFF, 16'hFFFF, 8'h30);

    // Random duty writes with all bits in PWM mode.
    for (int i = 0; i < 3 * Period; i++) step(1'b0, 16'hFFFF, 16'hFFFF, 8'($urandom));

    // Fully random inputs with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 499) == 0), 16'($urandom), 16'($urandom), 8'($urandom));
    end

    hold(2, 16'h0000, 16'h0000, 8'h00);
    repeat (3) @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
